// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: drives the fetch/execute phase bit, run/stop/halt
// handling, I/O stall with timeout and retired-instruction count. SEQ_STEP_EN adds single-step.
module cpu_sequencer #(
   parameter int CNT_W  = 16,
   parameter int IO_TMO = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             stop,
   input  logic             halt,
   input  logic             in1,
   input  logic             out1,
   input  logic             io_ack,
`ifdef SEQ_STEP_EN
   input  logic             step,
`endif
   output logic             sm,
   output logic             hold,
   output logic             commit,
   output logic             io_req,
   output logic             running,
   output logic             halted,
   output logic             io_err,
   output logic [CNT_W-1:0] icount
);

   localparam int TMO_W = (IO_TMO > 1) ? $clog2(IO_TMO + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = (IO_TMO > 0) ? TMO_W'(IO_TMO - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_IO_WAIT, S_HALTED
   } state_t;

   state_t           state, state_nxt;
   logic             stop_pend, stop_pend_nxt;
   logic             step_mode, step_mode_nxt;
   logic             io_err_nxt;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [CNT_W-1:0] icount_nxt;
   logic             io_instr, tmo_hit, go_step, in_run;

`ifdef SEQ_STEP_EN
   assign go_step = step & ~run;
`else
   assign go_step = 1'b0;
`endif

   assign io_instr = in1 | out1;
   // tmo_cnt holds completed IO_WAIT cycles, so the IO_TMO-th cycle sees IO_TMO-1
   assign tmo_hit  = (IO_TMO != 0) && (tmo_cnt == TMO_LAST);
   assign in_run   = (state == S_FETCH) || (state == S_EXEC) || (state == S_IO_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         stop_pend <= 1'b0;
         step_mode <= 1'b0;
         io_err    <= 1'b0;
         tmo_cnt   <= '0;
         icount    <= '0;
      end else begin
         state     <= state_nxt;
         stop_pend <= stop_pend_nxt;
         step_mode <= step_mode_nxt;
         io_err    <= io_err_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         icount    <= icount_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      stop_pend_nxt = stop_pend;
      step_mode_nxt = step_mode;
      io_err_nxt    = io_err;
      tmo_cnt_nxt   = tmo_cnt;
      icount_nxt    = icount;
      hold          = 1'b1;
      commit        = 1'b0;
      io_req        = 1'b0;

      if (in_run && stop)
         stop_pend_nxt = 1'b1;

      case (state)
         S_IDLE: begin
            if (run && !stop) begin
               state_nxt = S_FETCH;
            end else if (go_step) begin
               state_nxt     = S_FETCH;
               step_mode_nxt = 1'b1;
            end
         end
         S_FETCH: begin
            hold      = 1'b0;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (halt) begin
               state_nxt = S_HALTED;
            end else if (io_instr && !io_ack) begin
               // request is raised in the same cycle the stall is detected
               io_req      = 1'b1;
               state_nxt   = S_IO_WAIT;
               tmo_cnt_nxt = '0;
            end else begin
               commit = 1'b1;
            end
         end
         S_IO_WAIT: begin
            io_req = 1'b1;
            if (io_ack) begin
               commit = 1'b1;
            end else if (tmo_hit) begin
               state_nxt  = S_HALTED;
               io_err_nxt = 1'b1;
            end else if (IO_TMO != 0) begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
         end
         default: ;
      endcase

      // instruction boundary: the only place a pending stop or step end is honored
      if (commit) begin
         hold       = 1'b0;
         icount_nxt = icount + 1'b1;
         if (stop_pend || stop || step_mode) begin
            state_nxt     = S_IDLE;
            stop_pend_nxt = 1'b0;
            step_mode_nxt = 1'b0;
         end else begin
            state_nxt = S_FETCH;
         end
      end
   end

   assign sm      = (state == S_EXEC) || (state == S_IO_WAIT);
   assign running = in_run;
   assign halted  = (state == S_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer, checked every cycle against an instruction-level model.
module tb_cpu_sequencer;
   localparam int CNT_W  = 4;
   localparam int IO_TMO = 5;
`ifdef SEQ_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, run, stop, halt, in1, out1, io_ack, step;
   logic sm, hold, commit, io_req, running, halted, io_err;
   logic [CNT_W-1:0] icount;

   int n_cmp = 0, n_bad = 0;
   int io_hi, hold_hi, com_hi;

   // model: on = in an instruction, ex = in execute half, wcnt = IO_WAIT cycles so far
   bit m_on, m_ex, m_halt, m_err, m_stop, m_step;
   int m_wcnt, m_cnt;

   always #5 clk = ~clk;

   cpu_sequencer #(.CNT_W(CNT_W), .IO_TMO(IO_TMO)) dut (
      .clk(clk), .rst(rst), .run(run), .stop(stop), .halt(halt),
      .in1(in1), .out1(out1), .io_ack(io_ack),
`ifdef SEQ_STEP_EN
      .step(step),
`endif
      .sm(sm), .hold(hold), .commit(commit), .io_req(io_req),
      .running(running), .halted(halted), .io_err(io_err), .icount(icount)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // one clock: drive, check against the model mid-cycle, advance the model past the edge
   task automatic tick(input bit r, ru, sp, h, i1, o1, ak, st);
      bit e_sm, e_hold, e_com, e_req;
      rst = r; run = ru; stop = sp; halt = h; in1 = i1; out1 = o1; io_ack = ak; step = st;
      e_sm = m_on && m_ex;
      e_hold = 1'b1; e_com = 1'b0; e_req = 1'b0;
      if (m_on && !m_ex) e_hold = 1'b0;
      if (e_sm) begin
         if (m_wcnt == 0) begin
            if (h) ;
            else if ((i1 || o1) && !ak) e_req = 1'b1;
            else begin e_com = 1'b1; e_hold = 1'b0; end
         end else begin
            e_req = 1'b1;
            if (ak) begin e_com = 1'b1; e_hold = 1'b0; end
         end
      end
      #3;
      chk("sm", sm, e_sm);
      chk("hold", hold, e_hold);
      chk("commit", commit, e_com);
      chk("io_req", io_req, e_req);
      chk("running", running, m_on);
      chk("halted", halted, m_halt);
      chk("io_err", io_err, m_err);
      chk("icount", icount, m_cnt);
      io_hi += io_req; hold_hi += hold; com_hi += commit;
      @(posedge clk);
      if (r) begin
         m_on = 0; m_ex = 0; m_halt = 0; m_err = 0; m_stop = 0; m_step = 0; m_wcnt = 0; m_cnt = 0;
      end else if (m_halt) begin
      end else if (!m_on) begin
         if (ru && !sp) begin m_on = 1; m_ex = 0; end
         else if (STEP_EN && st && !ru) begin m_on = 1; m_ex = 0; m_step = 1; end
      end else begin
         if (sp) m_stop = 1;
         if (!m_ex) begin
            m_ex = 1; m_wcnt = 0;
         end else if (e_com) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (m_stop || m_step) begin m_on = 0; m_stop = 0; m_step = 0; end
            else m_ex = 0;
         end else if (m_wcnt == 0) begin
            if (h) begin m_halt = 1; m_on = 0; end
            else m_wcnt = 1;
         end else if (IO_TMO != 0 && m_wcnt == IO_TMO) begin
            m_halt = 1; m_on = 0; m_err = 1;
         end else m_wcnt++;
      end
      #1;
   endtask

   task automatic idle_n(input int n);
      for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; run = 0; stop = 0; halt = 0; in1 = 0; out1 = 0; io_ack = 0; step = 0;
      m_on = 0; m_ex = 0; m_halt = 0; m_err = 0; m_stop = 0; m_step = 0; m_wcnt = 0; m_cnt = 0;
      io_hi = 0; hold_hi = 0; com_hi = 0;
      @(posedge clk); #1;
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_hold", hold, 1);
      chk("rst_icount", icount, 0);
      chk("rst_running", running, 0);

      // four plain instructions
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      com_hi = 0;
      idle_n(8);
      chk("plain_icount", icount, 4);
      chk("plain_commits", com_hi, 4);

      // OUT stalled, ack three cycles after EXEC
      idle_n(1);
      io_hi = 0; hold_hi = 0; com_hi = 0;
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 1, 0);
      chk("out_io_req_cycles", io_hi, 4);
      chk("out_hold_cycles", hold_hi, 3);
      chk("out_commits", com_hi, 1);
      chk("out_icount", icount, 5);

      // stop during FETCH: the instruction retires, then idle; run+stop stays idle
      tick(0, 0, 1, 0, 0, 0, 0, 0);
      idle_n(1);
      chk("stop_running", running, 0);
      chk("stop_icount", icount, 6);
      tick(0, 1, 1, 0, 0, 0, 0, 0);
      chk("runstop_running", running, 0);

      // IN with no ack: timeout after IO_TMO wait cycles
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      idle_n(1);
      for (int k = 0; k < 1 + IO_TMO; k++) tick(0, 0, 0, 0, 1, 0, 0, 0);
      chk("tmo_halted", halted, 1);
      chk("tmo_io_err", io_err, 1);
      chk("tmo_icount", icount, 6);
      tick(0, 1, 0, 0, 0, 0, 0, 1);
      chk("tmo_run_ignored", halted, 1);
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      chk("tmo_rst_err", io_err, 0);

      // HALT in EXEC
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      idle_n(1);
      tick(0, 0, 0, 1, 0, 0, 0, 0);
      chk("halt_halted", halted, 1);
      chk("halt_icount", icount, 0);
      tick(1, 0, 0, 0, 0, 0, 0, 0);
      chk("halt_rst", halted, 0);

      // 2^CNT_W instructions wrap the counter to zero
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      com_hi = 0;
      idle_n(2 << CNT_W);
      chk("wrap_icount", icount, 0);
      chk("wrap_commits", com_hi, 1 << CNT_W);
      tick(1, 0, 0, 0, 0, 0, 0, 0);

      if (STEP_EN) begin
         tick(0, 0, 0, 0, 0, 0, 0, 1);
         idle_n(4);
         chk("step_icount", icount, 1);
         chk("step_running", running, 0);
      end

      for (int k = 0; k < 4000; k++)
         tick($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
              $urandom_range(39) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
              $urandom_range(2) == 0, $urandom_range(9) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
